// File: rtl/mem_bank_nrw_mask.sv
// mem_bank_nrw_mask
// -----------------
// N-port read/write memory bank with lane-masked writes and registered reads.
// All ports share one clock. When two or more ports write the same entry in
// one cycle, the lowest port index owns every overlapping lane. Lanes that do
// not overlap merge. Each losing port gets a one-cycle rw_collision pulse.
// After reset, a clear sequencer writes INIT_VALUE to every entry before any
// port access is accepted.
//
// Configuration macro:
//   MEM_BANK_NRW_BYPASS_EN  defined   -> write-first forwarding: a read
//                                        returns the merged post-write entry.
//                           undefined -> read-first; no forwarding logic.
//
// Ports (port p occupies slice p of each packed vector):
//   clk           in   single clock for all ports
//   rst_n         in   asynchronous active-low reset
//   rw_en         in   [NPORTS]        per-port access enable
//   rw_wmode      in   [NPORTS]        1 = write, 0 = read
//   rw_addr       in   [NPORTS*AW]     addresses
//   rw_wmask      in   [NPORTS*MW]     write lane masks
//   rw_wdata      in   [NPORTS*WIDTH]  write data
//   rw_rdata      out  [NPORTS*WIDTH]  registered read data
//   rw_collision  out  [NPORTS]        this port lost at least one lane
//   init_done     out                  clear sequence has completed
module mem_bank_nrw_mask #(
  parameter int               NPORTS     = 2,
  parameter int               DEPTH      = 16,
  parameter int               WIDTH      = 64,
  parameter int               MASK_GRAN  = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int              AW         = $clog2(DEPTH),
  localparam int              MW         = WIDTH / MASK_GRAN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        rw_en,
  input  logic [NPORTS-1:0]        rw_wmode,
  input  logic [NPORTS*AW-1:0]     rw_addr,
  input  logic [NPORTS*MW-1:0]     rw_wmask,
  input  logic [NPORTS*WIDTH-1:0]  rw_wdata,
  output logic [NPORTS*WIDTH-1:0]  rw_rdata,
  output logic [NPORTS-1:0]        rw_collision,
  output logic                     init_done
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // DEPTH need not be a power of two, so the address range check is real.
  localparam logic [AW:0]   DEPTH_W  = DEPTH[AW:0];
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              clr_we;

  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic [AW-1:0]     addr   [NPORTS];
  logic [MW-1:0]     wmask  [NPORTS];
  logic [WIDTH-1:0]  wdata  [NPORTS];
  logic [NPORTS-1:0] valid;
  logic [NPORTS-1:0] wr;
  logic [NPORTS-1:0] rd;
  logic [NPORTS-1:0] lost;
  logic [WIDTH-1:0]  rd_val [NPORTS];

  logic [WIDTH-1:0]  rdata_q [NPORTS];
  logic [NPORTS-1:0] coll_q;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  assign init_done = (state_q == ST_READY);

  // ---------------------------------------------------------------------------
  // Port decode and collision detection
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      addr[p]  = rw_addr[p*AW +: AW];
      wmask[p] = rw_wmask[p*MW +: MW];
      wdata[p] = rw_wdata[p*WIDTH +: WIDTH];
      valid[p] = ({1'b0, addr[p]} < DEPTH_W);
      wr[p]    = init_done & rw_en[p] &  rw_wmode[p] & valid[p];
      rd[p]    = init_done & rw_en[p] & ~rw_wmode[p];
    end
    // A port loses when any lower-indexed port writes a shared lane of the
    // same entry in the same cycle.
    for (int p = 0; p < NPORTS; p++) begin
      lost[p] = 1'b0;
      for (int q = 0; q < NPORTS; q++) begin
        if (q < p && wr[p] && wr[q] && addr[p] == addr[q] &&
            (wmask[p] & wmask[q]) != '0) begin
          lost[p] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; the clear sequencer initialises it, which
  // keeps it mappable onto RAM macros and avoids a huge reset fan-out.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[cnt_q] <= INIT_VALUE;
    end
    // Highest port applied first so port 0's assignment lands last and wins
    // each overlapping lane; disjoint lanes from all ports merge naturally.
    for (int p = NPORTS - 1; p >= 0; p--) begin
      if (wr[p]) begin
        for (int k = 0; k < MW; k++) begin
          if (wmask[p][k]) begin
            mem_q[addr[p]][k*MASK_GRAN +: MASK_GRAN] <=
              wdata[p][k*MASK_GRAN +: MASK_GRAN];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read value selection
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      rd_val[p] = valid[p] ? mem_q[addr[p]] : '0;
    end
`ifdef MEM_BANK_NRW_BYPASS_EN
    // Forward this cycle's writes, resolved with the same port priority as
    // the array update (port 0 applied last).
    for (int p = 0; p < NPORTS; p++) begin
      for (int q = NPORTS - 1; q >= 0; q--) begin
        if (valid[p] && wr[q] && addr[q] == addr[p]) begin
          for (int k = 0; k < MW; k++) begin
            if (wmask[q][k]) begin
              rd_val[p][k*MASK_GRAN +: MASK_GRAN] =
                wdata[q][k*MASK_GRAN +: MASK_GRAN];
            end
          end
        end
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Registered read data and collision flags
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '{default: '0};
      coll_q  <= '0;
    end else begin
      coll_q <= lost;
      for (int p = 0; p < NPORTS; p++) begin
        if (rd[p]) begin
          rdata_q[p] <= rd_val[p];
        end
      end
    end
  end

  always_comb begin
    rw_rdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rw_rdata[p*WIDTH +: WIDTH] = rdata_q[p];
    end
  end

  assign rw_collision = coll_q;

endmodule
